// File: rtl/mult_seq_par.sv
// Sequential radix-2 shift-add multiplier with operand parity checking.
// One transaction at a time: capture, check parity, WIDTH add/shift steps, report.
module mult_seq_par #(
    parameter int WIDTH      = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic [WIDTH-1:0]     arg_a,
    input  logic                 arg_a_parity,
    input  logic [WIDTH-1:0]     arg_b,
    input  logic                 arg_b_parity,
    input  logic                 signed_mode,
    output logic                 ack,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_parity,
    output logic                 result_rdy,
    output logic                 arg_parity_error,
    output logic                 busy
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ACK, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             a_par_q, b_par_q, sm_q;
    logic [PW-1:0]    acc, mcand;
    logic [WIDTH-1:0] mplr;
    logic [CW-1:0]    cnt;

    logic             par_ok, neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    step_acc, final_prod;

    always_comb begin
        par_ok     = ((^a_q ^ PARITY_ODD) == a_par_q) && ((^b_q ^ PARITY_ODD) == b_par_q);
        neg        = sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
        mag_a      = (sm_q & a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
        mag_b      = (sm_q & b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
        step_acc   = acc + (mplr[0] ? mcand : '0);
        final_prod = neg ? (~step_acc + PW'(1)) : step_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            a_q              <= '0;
            b_q              <= '0;
            a_par_q          <= 1'b0;
            b_par_q          <= 1'b0;
            sm_q             <= 1'b0;
            acc              <= '0;
            mcand            <= '0;
            mplr             <= '0;
            cnt              <= '0;
            ack              <= 1'b0;
            result           <= '0;
            result_parity    <= 1'b0;
            result_rdy       <= 1'b0;
            arg_parity_error <= 1'b0;
            busy             <= 1'b0;
        end else begin
            ack        <= 1'b0;
            result_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        a_q     <= arg_a;
                        b_q     <= arg_b;
                        a_par_q <= arg_a_parity;
                        b_par_q <= arg_b_parity;
                        sm_q    <= signed_mode;
                        ack     <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    if (!par_ok) begin
                        result           <= '0;
                        result_parity    <= PARITY_ODD;
                        arg_parity_error <= 1'b1;
                        result_rdy       <= 1'b1;
                        state            <= DONE;
                    end else begin
                        acc   <= '0;
                        mcand <= {{WIDTH{1'b0}}, mag_a};
                        mplr  <= mag_b;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= step_acc;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CW'(1);
                    // Last step: publish the signed-corrected sum directly.
                    if (cnt == CW'(WIDTH - 1)) begin
                        result           <= final_prod;
                        result_parity    <= ^final_prod ^ PARITY_ODD;
                        arg_parity_error <= 1'b0;
                        result_rdy       <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_par.sv
// Directed bench for mult_seq_par (WIDTH=16, even parity).
module tb_mult_seq_par;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [15:0] arg_a, arg_b;
    logic        arg_a_parity, arg_b_parity, signed_mode;
    logic        ack, result_parity, result_rdy, arg_parity_error, busy;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    mult_seq_par #(.WIDTH(16), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .arg_a(arg_a), .arg_a_parity(arg_a_parity),
        .arg_b(arg_b), .arg_b_parity(arg_b_parity),
        .signed_mode(signed_mode), .ack(ack), .result(result),
        .result_parity(result_parity), .result_rdy(result_rdy),
        .arg_parity_error(arg_parity_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic bad_b);
        arg_a        = a;
        arg_a_parity = ^a;
        arg_b        = b;
        arg_b_parity = (^b) ^ bad_b;
        signed_mode  = sm;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input logic bad_b, input logic [31:0] er,
                          input logic ep, input logic ee, input int elat);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        drive(a, b, sm, bad_b);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        drive(~a, ~b, ~sm, 1'b0);
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check({tag, " ack"}, 64'(ack), 64'(1));
                check({tag, " busy"}, 64'(busy), 64'(1));
            end
            if (n == 2) check({tag, " ack_off"}, 64'(ack), 64'(0));
            if (result_rdy) lat = n;
        end
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " result"}, 64'(result), 64'(er));
        check({tag, " parity"}, 64'(result_parity), 64'(ep));
        check({tag, " perr"}, 64'(arg_parity_error), 64'(ee));
        @(negedge clk);
        check({tag, " rdy_pulse"}, 64'(result_rdy), 64'(0));
        check({tag, " idle"}, 64'(busy), 64'(0));
        check({tag, " hold"}, 64'(result), 64'(er));
    endtask

    initial begin
        int pulses;
        int rdy_seen;
        logic [31:0] r1, r2;
        rst_n = 1'b0;
        req   = 1'b0;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        #2;
        check("rst ack", 64'(ack), 64'(0));
        check("rst result", 64'(result), 64'(0));
        check("rst rpar", 64'(result_parity), 64'(0));
        check("rst rdy", 64'(result_rdy), 64'(0));
        check("rst perr", 64'(arg_parity_error), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        #20 rst_n = 1'b1;

        run_op("s3xm4",   16'h0003, 16'hFFFC, 1'b1, 1'b0, 32'hFFFF_FFF4, 1'b1, 1'b0, 18);
        run_op("sminsq",  16'h8000, 16'h8000, 1'b1, 1'b0, 32'h4000_0000, 1'b1, 1'b0, 18);
        run_op("umax",    16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE_0001, 1'b0, 1'b0, 18);
        run_op("sminx1",  16'h8000, 16'h0001, 1'b1, 1'b0, 32'hFFFF_8000, 1'b1, 1'b0, 18);
        run_op("u8000x1", 16'h8000, 16'h0001, 1'b0, 1'b0, 32'h0000_8000, 1'b1, 1'b0, 18);
        run_op("badpar",  16'h0011, 16'h0022, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 2);

        // Abort in the 8th CALC cycle; start from a nonzero held result.
        run_op("pre_rst", 16'h0003, 16'h0005, 1'b0, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 18);
        @(posedge clk); #1;
        drive(16'h1234, 16'h0002, 1'b0, 1'b0);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        for (int n = 1; n <= 9; n++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort ack", 64'(ack), 64'(0));
        check("abort result", 64'(result), 64'(0));
        check("abort rpar", 64'(result_parity), 64'(0));
        check("abort rdy", 64'(result_rdy), 64'(0));
        check("abort perr", 64'(arg_parity_error), 64'(0));
        check("abort busy", 64'(busy), 64'(0));
        #8 rst_n = 1'b1;
        rdy_seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (result_rdy) rdy_seen = 1;
        end
        check("abort no_rdy", 64'(rdy_seen), 64'(0));
        run_op("u5x7", 16'h0005, 16'h0007, 1'b0, 1'b0, 32'd35, 1'b1, 1'b0, 18);

        // req held high across two transactions, operands disturbed mid-CALC.
        pulses = 0;
        r1 = '0;
        r2 = '0;
        @(posedge clk); #1;
        drive(16'h0002, 16'h0002, 1'b0, 1'b0);
        req = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 8)  drive(16'h0006, 16'hFFFF, 1'b1, 1'b0);
            if (n == 20) req = 1'b0;
            if (n == 28) drive(16'h1234, 16'h0F0F, 1'b0, 1'b0);
            if (result_rdy) begin
                pulses++;
                if (pulses == 1) begin
                    r1 = result;
                    check("b2b rdy1_at", 64'(n), 64'(18));
                end else begin
                    r2 = result;
                    check("b2b rdy2_at", 64'(n), 64'(37));
                end
            end
        end
        check("b2b pulses", 64'(pulses), 64'(2));
        check("b2b r1", 64'(r1), 64'(32'h0000_0004));
        check("b2b r2", 64'(r2), 64'(32'hFFFF_FFFA));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
